// File: rtl/seg_scan_ctrl_pkg.sv
// seg_scan_ctrl_pkg
// Shared definitions for the 4-digit 7-segment scan controller:
//   - FSM state encoding
//   - active-low gfedcba glyph constants (common-anode)
//   - display limits and the double-dabble step count
//   - helper functions for saturation and the add-3 correction
package seg_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [6:0] GLYPH_0     = 7'b1000000;
  localparam logic [6:0] GLYPH_1     = 7'b1111001;
  localparam logic [6:0] GLYPH_2     = 7'b0100100;
  localparam logic [6:0] GLYPH_3     = 7'b0110000;
  localparam logic [6:0] GLYPH_4     = 7'b0011001;
  localparam logic [6:0] GLYPH_5     = 7'b0010010;
  localparam logic [6:0] GLYPH_6     = 7'b0000010;
  localparam logic [6:0] GLYPH_7     = 7'b1111000;
  localparam logic [6:0] GLYPH_8     = 7'b0000000;
  localparam logic [6:0] GLYPH_9     = 7'b0010000;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

  localparam logic [13:0] MAX_DISPLAY = 14'd9999;
  localparam int          CONV_STEPS  = 14;

  function automatic logic [13:0] saturate(input logic [13:0] v);
    return (v > MAX_DISPLAY) ? MAX_DISPLAY : v;
  endfunction

  // Double-dabble correction: any BCD nibble >= 5 gets +3 so the
  // following left shift carries correctly into the next decade.
  function automatic logic [15:0] add3(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_seg7_decoder.sv
// seg7_decoder
// Combinational BCD digit to 7-segment glyph, active-low gfedcba.
// Ports:
//   bcd   in  4  BCD digit (values above 9 decode to blank)
//   glyph out 7  segment pattern {g,f,e,d,c,b,a}, 0 = segment lit
module seg7_decoder
  import seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = GLYPH_BLANK;
    case (bcd)
      4'd0: glyph = GLYPH_0;
      4'd1: glyph = GLYPH_1;
      4'd2: glyph = GLYPH_2;
      4'd3: glyph = GLYPH_3;
      4'd4: glyph = GLYPH_4;
      4'd5: glyph = GLYPH_5;
      4'd6: glyph = GLYPH_6;
      4'd7: glyph = GLYPH_7;
      4'd8: glyph = GLYPH_8;
      4'd9: glyph = GLYPH_9;
      default: glyph = GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
// Loads a binary value (saturated to 9999), converts it to BCD with a
// sequential double-dabble, commits the digits to a display register and
// time-multiplexes them onto a shared segment bus.
// Ports:
//   clk      in  1   system clock
//   rst_n    in  1   synchronous active-low reset
//   load     in  1   request to display value (ignored while busy)
//   value    in  14  unsigned binary value
//   busy     out 1   conversion in progress
//   disp     out 7   segments {g,f,e,d,c,b,a}, active-low
//   seg_sel  out 4   digit select, one-hot active-low, bit0 = units
// Build option: define SEG_SCAN_LEADING_ZERO_BLANK_EN to blank leading zeros.
//
// state  | meaning
// IDLE   | waiting for load; display register holds last committed value
// CONV   | one double-dabble iteration per cycle, 14 in total
// COMMIT | copy BCD result into the display register
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int SCAN_W   = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [13:0] value,
  output logic        busy,
  output logic [6:0]  disp,
  output logic [3:0]  seg_sel
);

  localparam logic [SCAN_W-1:0] PRE_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [3:0]        CNT_LAST = 4'(CONV_STEPS - 1);

  state_t            state_q, state_d;
  logic [13:0]       bin_q;
  logic [15:0]       bcd_q;
  logic [3:0]        cnt_q;
  logic [15:0]       disp_reg_q;
  logic [1:0]        dig_idx_q;
  logic [SCAN_W-1:0] pre_q;
  logic [29:0]       shifted;
  logic [3:0]        cur_nib;
  logic [6:0]        dec_glyph;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load) state_d = CONV;
      CONV:    if (cnt_q == CNT_LAST) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign shifted = {add3(bcd_q), bin_q} << 1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      disp_reg_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load) begin
            bin_q <= saturate(value);
            bcd_q <= '0;
            cnt_q <= '0;
          end
        end
        CONV: begin
          bcd_q <= shifted[29:14];
          bin_q <= shifted[13:0];
          cnt_q <= cnt_q + 4'd1;
        end
        COMMIT: disp_reg_q <= bcd_q;
        default: ;
      endcase
    end
  end

  // Scan prescaler and digit index; free-running, independent of the FSM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_q     <= '0;
      dig_idx_q <= '0;
    end else if (pre_q == PRE_LAST) begin
      pre_q     <= '0;
      dig_idx_q <= dig_idx_q + 2'd1;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

  always_comb begin
    seg_sel = 4'b1110;
    case (dig_idx_q)
      2'd0: seg_sel = 4'b1110;
      2'd1: seg_sel = 4'b1101;
      2'd2: seg_sel = 4'b1011;
      2'd3: seg_sel = 4'b0111;
      default: seg_sel = 4'b1110;
    endcase
  end

  assign cur_nib = disp_reg_q[dig_idx_q*4 +: 4];

  seg7_decoder u_dec (
    .bcd   (cur_nib),
    .glyph (dec_glyph)
  );

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
  // Blanking looks only at the committed display register so an in-flight
  // conversion never flickers the leading digits.
  logic [3:0] blank;
  always_comb begin
    blank    = 4'b0000;
    blank[3] = (disp_reg_q[15:12] == 4'd0);
    blank[2] = blank[3] && (disp_reg_q[11:8] == 4'd0);
    blank[1] = blank[2] && (disp_reg_q[7:4] == 4'd0);
  end
  assign disp = blank[dig_idx_q] ? GLYPH_BLANK : dec_glyph;
`else
  assign disp = dec_glyph;
`endif

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [13:0] value = '0;
  logic        busy;
  logic [6:0]  disp;
  logic [3:0]  seg_sel;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.SCAN_DIV(4), .SCAN_W(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .value   (value),
    .busy    (busy),
    .disp    (disp),
    .seg_sel (seg_sel)
  );

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  localparam logic [6:0] GLY [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [3:0] SEL [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] exp_glyph(input logic [15:0] bcd, input int d);
    logic [3:0] n;
    n = bcd[d*4 +: 4];
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    if (d == 3 && bcd[15:12] == 4'd0) return 7'b1111111;
    if (d == 2 && bcd[15:8]  == 8'd0) return 7'b1111111;
    if (d == 1 && bcd[15:4]  == 12'd0) return 7'b1111111;
`endif
    return GLY[n];
  endfunction

  // Watches one full scan frame and compares each digit's glyph.
  task automatic check_frame(input string tag, input logic [15:0] e);
    logic [6:0] g [4];
    bit seen [4];
    int valid;
    int idx;
    valid = 0;
    for (int d = 0; d < 4; d++) begin
      seen[d] = 1'b0;
      g[d] = '0;
    end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      idx = -1;
      for (int d = 0; d < 4; d++) if (seg_sel == SEL[d]) idx = d;
      if (idx >= 0) begin
        valid++;
        seen[idx] = 1'b1;
        g[idx] = disp;
      end
    end
    check({tag, "_onehot_samples"}, valid, 16);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("%s_seen_d%0d", tag, d), seen[d], 1);
      check($sformatf("%s_glyph_d%0d", tag, d), g[d], exp_glyph(e, d));
    end
  endtask

  // Monitor: on every busy falling edge, verify duration and displayed digits.
  initial begin
    int bc;
    bit prev;
    logic [15:0] e;
    bc = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bc = 0;
        prev = 1'b0;
      end else if (busy) begin
        bc++;
        prev = 1'b1;
      end else if (prev) begin
        prev = 1'b0;
        check("busy_cycles", bc, 15);
        bc = 0;
        check("commit_queue_size", exp_q.size(), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_frame($sformatf("frame_%04h", e), e);
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("busy_released", busy, 0);
    repeat (20) @(negedge clk);
  endtask

  task automatic do_load(input logic [13:0] v, input logic [15:0] e);
    exp_q.push_back(e);
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_seg_sel", seg_sel, 4'b1110);
    check("reset_disp", disp, 7'b1000000);
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check($sformatf("scan_step_%0d", k), seg_sel, SEL[(k / 4) % 4]);
    end

    do_load(14'd1234, 16'h1234);

    // second load while busy must be dropped
    exp_q.push_back(16'h5678);
    value = 14'd5678;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    repeat (3) @(negedge clk);
    value = 14'd42;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    check("busy_during_drop", busy, 1);
    wait_idle();

    do_load(14'd16383, 16'h9999);
    do_load(14'd0,     16'h0000);
    do_load(14'd9999,  16'h9999);
    do_load(14'd10000, 16'h9999);
    do_load(14'd42,    16'h0042);

    // reset in the middle of a conversion: nothing may be committed
    value = 14'd8765;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_busy", busy, 0);
    rst_n = 1'b1;
    check_frame("after_reset", 16'h0000);
    repeat (30) @(negedge clk);
    check("no_late_commit_busy", busy, 0);
    check("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Controller for the 4-digit multiplexed 7-segment display.
- Accepts a binary value (0-9999) through a load handshake and converts it to BCD over 14 cycles using sequential double-dabble.
- Commits the four digits to a display register, then time-shares the single segment bus across the four digits at a programmable scan rate.
- Replaces the free-running divider/segment-counter pair in the top level. It is the sole owner of the segment and digit-select pins.

Parameters:
- SCAN_DIV, 50000, clk cycles each digit stays selected; legal range 2..2^20.
- SCAN_W, 20, width of the scan prescaler counter; must satisfy 2^SCAN_W >= SCAN_DIV.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- load  input  1  request to display `value`; sampled every clk edge.
- value  input  14  unsigned binary value to display.
- busy  output  1  high while a conversion is in progress; load is ignored while high.
- disp  output  7  segment drive {g,f,e,d,c,b,a}, active-low, common-anode.
- seg_sel  output  4  digit select, one-hot active-low; bit0 = units, bit3 = thousands.

Behaviour:
- All state is registered. rst_n low at a clk edge forces:
  - FSM to IDLE, busy=0;
  - display register = 0000, digit index = 0, prescaler = 0;
  - therefore seg_sel=4'b1110 and disp=7'b1000000 (glyph "0") from the first edge after reset.
- Reset asserted mid-conversion aborts it. Display shows 0000; nothing partial is committed.
- FSM states:
  - IDLE: if load=1 at an edge, latch min(value, 9999) into the shift register, clear the BCD accumulator, set iteration count=0, go to CONV. busy=1 from that edge.
  - CONV: each cycle apply add-3 to every BCD nibble >=5, then shift the combined {bcd,bin} left by 1 and increment the count. After the 14th shift go to COMMIT.
  - COMMIT: copy the 16-bit BCD result into the display register, return to IDLE, busy=0.
- Timing:
  - busy is high for exactly 15 cycles: 14 CONV plus 1 COMMIT.
  - New digits appear on disp from the edge leaving COMMIT, i.e. 15 cycles after the load edge.
  - The previous value stays displayed throughout the conversion.
- load while busy=1 is dropped; there is no queueing.
- load held high continuously retriggers a new conversion from the cycle IDLE is re-entered, sampling `value` each time.
- Saturation: any value >9999 (10000..16383) is displayed as 9999.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1 and wraps.
  - On wrap the digit index advances 0→1→2→3→0, and seg_sel/disp change on that same edge.
  - Each digit is active for exactly SCAN_DIV cycles; the full frame is 4*SCAN_DIV cycles.
  - Scan runs independently of the FSM and is never paused by busy or load.
- disp is a combinational decode of the selected display nibble. It is glitch-free relative to seg_sel because both come from registers updated on the same edge.
- Glyphs, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - nibble >9 (unreachable) = 1111111 (blank).

Optional Feature:
- Macro: SEG_SCAN_LEADING_ZERO_BLANK_EN.
- Defined:
  - thousands digit blank if zero;
  - hundreds blank if it and thousands are zero;
  - tens blank if it, hundreds and thousands are zero;
  - units always shown.
  - Blanked digit: disp=7'b1111111 while its seg_sel bit is still driven low, so scan timing is unchanged.
  - Blank flags are derived from the display register, never from the in-flight conversion.
- Undefined: all four digits are always shown, leading zeros included.

Decomposition:
- Shared package/include:
  - FSM state encoding (IDLE=2'd0, CONV=2'd1, COMMIT=2'd2);
  - the ten glyph constants plus GLYPH_BLANK;
  - MAX_DISPLAY=14'd9999;
  - CONV_STEPS=14.
- One sub-module: seg7_decoder, a 4-bit BCD in → 7-bit active-low glyph out, purely combinational. It is reused by any other display block.
- The FSM, double-dabble datapath and scan counter stay in seg_scan_ctrl.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, release → seg_sel=1110, disp=1000000, busy=0; with SCAN_DIV=4, seg_sel steps 1110→1101→1011→0111→1110 every 4 cycles.
- Conversion: load=1 with value=1234 for one cycle → busy high exactly 15 cycles; afterwards digits read 4,3,2,1 on seg_sel bits 0..3 with glyphs 0011001, 0110000, 0100100, 1111001.
- Busy drop: load value=5678, then load value=42 at cycle +5 → final display 5678, busy still falls at cycle 15.
- Saturation and boundaries: value=16383 → 9999; value=0 → 0000; value=9999 → 9999; value=10000 → 9999.
- Reset mid-operation: load 8765, assert rst_n=0 at cycle +7 → display 0000, busy=0, no later commit.
- Macro build with SEG_SCAN_LEADING_ZERO_BLANK_EN: value=42 → thousands and hundreds disp=1111111, tens=0011001, units=0100100; value=0 → units shows 1000000, others blank.
